// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register tags for rename. Supplies one tag per
// cycle, accepts freed tags from the ROB and restores the head from saved checkpoints.
module phys_reg_free_list #(
  parameter int FREE_LIST_DEPTH      = 32,
  parameter int LOG_FREE_LIST_DEPTH  = 5,
  parameter int CHECKPOINT_COLUMNS   = 4,
  parameter int PHYS_REG_WIDTH       = 6,
  parameter int CHECKPOINT_COL_WIDTH = 2
) (
  input  logic                            CLK,
  input  logic                            nRST,
  output logic                            dequeue_valid,
  output logic [PHYS_REG_WIDTH-1:0]       dequeue_phys_reg_tag,
  input  logic                            dequeue_ready,
  input  logic                            enqueue_valid,
  input  logic [PHYS_REG_WIDTH-1:0]       enqueue_phys_reg_tag,
  input  logic                            save_checkpoint_valid,
  input  logic [CHECKPOINT_COL_WIDTH-1:0] save_checkpoint_column,
  input  logic                            restore_checkpoint_valid,
  input  logic [CHECKPOINT_COL_WIDTH-1:0] restore_checkpoint_column,
  output logic [LOG_FREE_LIST_DEPTH:0]    free_count,
  output logic                            overflow_error
);

  localparam int PTR_W = LOG_FREE_LIST_DEPTH + 1;

  logic [PHYS_REG_WIDTH-1:0] entries_q [FREE_LIST_DEPTH];
  logic [PHYS_REG_WIDTH-1:0] entries_d [FREE_LIST_DEPTH];
  logic [PTR_W-1:0]          head_q, head_d;
  logic [PTR_W-1:0]          tail_q, tail_d;
  logic [PTR_W-1:0]          ckpt_head_q [CHECKPOINT_COLUMNS];
  logic [PTR_W-1:0]          ckpt_head_d [CHECKPOINT_COLUMNS];
  logic                      overflow_q, overflow_d;

  logic [LOG_FREE_LIST_DEPTH-1:0] head_idx, tail_idx;
  logic                           empty, full, deq_fire, enq_fire;
  logic [PTR_W-1:0]               head_inc;

  assign head_idx = head_q[LOG_FREE_LIST_DEPTH-1:0];
  assign tail_idx = tail_q[LOG_FREE_LIST_DEPTH-1:0];
  assign head_inc = head_q + PTR_W'(1);
  assign empty    = (head_q == tail_q);
  assign full     = (head_idx == tail_idx) &&
                    (head_q[LOG_FREE_LIST_DEPTH] != tail_q[LOG_FREE_LIST_DEPTH]);

  // Restore owns the head this cycle, so it suppresses the dequeue handshake.
  assign deq_fire = !empty && dequeue_ready && !restore_checkpoint_valid;
  // A same-cycle dequeue frees the slot the enqueue writes into, so full is no obstacle.
  assign enq_fire = enqueue_valid && (!full || deq_fire);

  assign dequeue_valid        = !empty;
  assign dequeue_phys_reg_tag = entries_q[head_idx];
  assign free_count           = tail_q - head_q;
  assign overflow_error       = overflow_q;

  always_comb begin
    entries_d   = entries_q;
    head_d      = head_q;
    tail_d      = tail_q;
    ckpt_head_d = ckpt_head_q;
    overflow_d  = overflow_q;

    if (restore_checkpoint_valid) begin
      head_d = ckpt_head_q[restore_checkpoint_column];
    end else begin
      if (deq_fire) head_d = head_inc;
      if (save_checkpoint_valid) begin
        ckpt_head_d[save_checkpoint_column] = deq_fire ? head_inc : head_q;
      end
    end

    if (enq_fire) begin
      entries_d[tail_idx] = enqueue_phys_reg_tag;
      tail_d              = tail_q + PTR_W'(1);
    end else if (enqueue_valid) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int i = 0; i < FREE_LIST_DEPTH; i++) begin
        entries_q[i] <= PHYS_REG_WIDTH'(FREE_LIST_DEPTH + i);
      end
      head_q <= '0;
      tail_q <= {1'b1, {LOG_FREE_LIST_DEPTH{1'b0}}};
      for (int c = 0; c < CHECKPOINT_COLUMNS; c++) begin
        ckpt_head_q[c] <= '0;
      end
      overflow_q <= 1'b0;
    end else begin
      entries_q   <= entries_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      ckpt_head_q <= ckpt_head_d;
      overflow_q  <= overflow_d;
    end
  end

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Bench for phys_reg_free_list: directed scenarios plus random traffic, checked
// against a sequence-number model of the free list through an expected-value queue.
module tb_phys_reg_free_list;

  localparam int W = 14;  // {valid, tag[5:0], count[5:0], overflow}

  logic       CLK = 1'b0;
  logic       nRST;
  logic       dequeue_valid;
  logic [5:0] dequeue_phys_reg_tag;
  logic       dequeue_ready;
  logic       enqueue_valid;
  logic [5:0] enqueue_phys_reg_tag;
  logic       save_checkpoint_valid;
  logic [1:0] save_checkpoint_column;
  logic       restore_checkpoint_valid;
  logic [1:0] restore_checkpoint_column;
  logic [5:0] free_count;
  logic       overflow_error;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  // Model: every tag ever enqueued gets a sequence number; head/tail are plain
  // counters into that log and checkpoints remember a head sequence number.
  int tag_log[$];
  int deq_n;
  int enq_n;
  int ckpt_m[4];
  bit ovf_m;

  phys_reg_free_list dut (
    .CLK                      (CLK),
    .nRST                     (nRST),
    .dequeue_valid            (dequeue_valid),
    .dequeue_phys_reg_tag     (dequeue_phys_reg_tag),
    .dequeue_ready            (dequeue_ready),
    .enqueue_valid            (enqueue_valid),
    .enqueue_phys_reg_tag     (enqueue_phys_reg_tag),
    .save_checkpoint_valid    (save_checkpoint_valid),
    .save_checkpoint_column   (save_checkpoint_column),
    .restore_checkpoint_valid (restore_checkpoint_valid),
    .restore_checkpoint_column(restore_checkpoint_column),
    .free_count               (free_count),
    .overflow_error           (overflow_error)
  );

  // Clock
  always #5 CLK = ~CLK;

  function automatic void model_reset();
    tag_log.delete();
    for (int i = 0; i < 32; i++) tag_log.push_back(32 + i);
    deq_n = 0;
    enq_n = 32;
    for (int c = 0; c < 4; c++) ckpt_m[c] = 0;
    ovf_m = 1'b0;
  endfunction

  function automatic logic [W-1:0] model_exp();
    int  cnt;
    int  tag;
    bit  v;
    cnt = enq_n - deq_n;
    v   = (cnt > 0);
    tag = v ? tag_log[deq_n] : 0;
    return {v, 6'(tag), 6'(cnt), ovf_m};
  endfunction

  // Driver: one call per cycle. Pushes the outputs expected during this cycle,
  // drives the inputs, then advances the model past the coming rising edge.
  task automatic drive(input bit rst_n, input bit rdy, input bit ev, input logic [5:0] et,
                       input bit sv, input logic [1:0] sc, input bit rv, input logic [1:0] rc);
    int  cnt;
    bit  deq;
    bit  enq;
    bit  r_v;
    r_v = rv;
    @(negedge CLK);
    exp_q.push_back(model_exp());
    if (!rst_n) begin
      model_reset();
    end else begin
      cnt = enq_n - deq_n;
      // A restore is only legal to a head the ROB could really return to.
      if (r_v) begin
        enq = ev && (cnt < 32);
        if (ckpt_m[rc] > deq_n || (enq_n + int'(enq)) - ckpt_m[rc] > 32) r_v = 1'b0;
      end
      deq = (cnt > 0) && rdy && !r_v;
      enq = ev && ((cnt < 32) || deq);
      if (ev && !enq) ovf_m = 1'b1;
      if (enq) begin
        tag_log.push_back(int'(et));
        enq_n++;
      end
      if (r_v) begin
        deq_n = ckpt_m[rc];
      end else begin
        if (sv) ckpt_m[sc] = deq_n + int'(deq);
        deq_n = deq_n + int'(deq);
      end
    end
    nRST                      = rst_n;
    dequeue_ready             = rdy;
    enqueue_valid             = ev;
    enqueue_phys_reg_tag      = et;
    save_checkpoint_valid     = sv;
    save_checkpoint_column    = sc;
    restore_checkpoint_valid  = r_v;
    restore_checkpoint_column = rc;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 6'd0, 0, 2'd0, 0, 2'd0);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 6'd0, 0, 2'd0, 0, 2'd0);
  endtask

  // Monitor: pops one expectation per cycle and compares against the DUT.
  initial begin
    logic [W-1:0] exp_v;
    logic [W-1:0] got_v;
    forever begin
      @(negedge CLK);
      #2;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        got_v = {dequeue_valid, dequeue_valid ? dequeue_phys_reg_tag : 6'd0,
                 free_count, overflow_error};
        total++;
        if (got_v !== exp_v) begin
          bad++;
          $display("FAIL outputs t=%0t: got valid=%0b tag=%0d count=%0d ovf=%0b, need valid=%0b tag=%0d count=%0d ovf=%0b",
                   $time, got_v[13], got_v[12:7], got_v[6:1], got_v[0],
                   exp_v[13], exp_v[12:7], exp_v[6:1], exp_v[0]);
        end
      end
    end
  end

  initial begin
    int p;
    nRST = 1'b0;
    dequeue_ready = 1'b0;
    enqueue_valid = 1'b0;
    enqueue_phys_reg_tag = '0;
    save_checkpoint_valid = 1'b0;
    save_checkpoint_column = '0;
    restore_checkpoint_valid = 1'b0;
    restore_checkpoint_column = '0;
    model_reset();
    repeat (2) @(posedge CLK);

    // Drain all 32 reset tags, then see empty.
    for (int i = 0; i < 33; i++) drive(1, 1, 0, 6'd0, 0, 2'd0, 0, 2'd0);
    // From empty: enqueue 5, offered next cycle, then dequeue back to empty.
    drive(1, 1, 1, 6'd5, 0, 2'd0, 0, 2'd0);
    drive(1, 1, 0, 6'd0, 0, 2'd0, 0, 2'd0);
    idle(2);

    // Checkpoint save with dequeue, three more dequeues, a real free, then restore.
    do_reset();
    drive(1, 1, 0, 6'd0, 1, 2'd2, 0, 2'd0);
    for (int i = 0; i < 3; i++) drive(1, 1, 0, 6'd0, 0, 2'd0, 0, 2'd0);
    drive(1, 0, 1, 6'd7, 0, 2'd0, 0, 2'd0);
    drive(1, 1, 0, 6'd0, 0, 2'd0, 1, 2'd2);
    idle(2);

    // Wrap-around at full with simultaneous dequeue and enqueue.
    do_reset();
    for (int i = 0; i < 70; i++) drive(1, 1, 1, 6'(i % 64), 0, 2'd0, 0, 2'd0);
    // Enqueue alone while full: dropped and sticky overflow.
    drive(1, 0, 1, 6'd44, 0, 2'd0, 0, 2'd0);
    idle(3);
    for (int i = 0; i < 33; i++) drive(1, 1, 0, 6'd0, 0, 2'd0, 0, 2'd0);

    // Reset in the middle of traffic ignores that cycle's inputs.
    do_reset();
    for (int i = 0; i < 10; i++) drive(1, 1, 0, 6'd0, 0, 2'd0, 0, 2'd0);
    drive(0, 1, 1, 6'd9, 0, 2'd0, 0, 2'd0);
    idle(2);

    // Random traffic with alternating enqueue bias to sweep occupancy.
    for (int i = 0; i < 3000; i++) begin
      p = ((i / 150) % 2 == 1) ? 75 : 35;
      drive($urandom_range(0, 299) != 0,
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 99) < p,
            6'($urandom_range(0, 63)),
            $urandom_range(0, 7) == 0,
            2'($urandom_range(0, 3)),
            $urandom_range(0, 9) == 0,
            2'($urandom_range(0, 3)));
    end
    idle(2);

    repeat (3) @(negedge CLK);
    #5;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d unchecked entries, need 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
